// File: rtl/parity_rx_pkg.sv
// Shared definitions for the parity frame receiver.
//  rx_state_t : receive FSM states (idle, data bits, parity bit, stop bit)
//  PAR_EVEN / PAR_ODD : values of the ODD_PARITY parameter
package parity_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Output word handshake bus of the parity frame receiver.
//  out_data    : received data word
//  out_par_err : parity mismatch for out_data
//  out_frm_err : stop bit sampled low for out_data
//  out_valid   : out_* holds a word, held until accepted
//  out_ready   : consumer accepts when out_valid & out_ready
// master = receiver side, slave = consumer side.
interface parity_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_par_err;
    logic              out_frm_err;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data, out_par_err, out_frm_err, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_par_err, out_frm_err, out_valid,
        output out_ready
    );
endinterface

// File: rtl/parity_tree.sv
// Combinational XOR reduction over W bits.
//  din : input vector
//  p   : XOR of all bits of din
// Bits are first folded in groups of three (matching the transmit-side
// generator structure), then the group results are reduced.
module parity_tree #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] din,
    output logic         p
);
    localparam int unsigned G = (W + 2) / 3;

    logic [G-1:0] grp;

    always_comb begin
        grp = '0;
        for (int unsigned g = 0; g < G; g++) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (g * 3 + k < W) begin
                    grp[g] = grp[g] ^ din[g * 3 + k];
                end
            end
        end
    end

    assign p = ^grp;
endmodule

// File: rtl/parity_frame_rx.sv
// Receive end of the parity path: deserialises start / DATA_W data bits
// (LSB first) / parity / stop, checks parity and stop bit, and presents the
// word with error flags on a valid/ready bus.
//  clk       : rising-edge clock
//  reset     : asynchronous active-high reset
//  bit_en    : bit-sample strobe; serial_in only sampled when high
//  serial_in : serial line, idle high
//  bus       : output word handshake (master side)
//  overrun   : sticky, a frame was dropped while a word was still pending
//  err_count : saturating count of frames with parity or framing error
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = PAR_EVEN,
    parameter int ERRCNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_en,
    input  logic                  serial_in,
    parity_frame_rx_if.master     bus,
    output logic                  overrun,
    output logic [ERRCNT_W-1:0]   err_count
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bit;
    logic              p;
    logic              par_err;
    logic              frm_err;

    parity_tree #(.W(DATA_W + 1)) u_parity_tree (
        .din ({shift_reg, par_bit}),
        .p   (p)
    );

    assign par_err = (ODD_PARITY == PAR_ODD) ? ~p : p;
    assign frm_err = ~serial_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            par_bit         <= 1'b0;
            bus.out_data    <= '0;
            bus.out_par_err <= 1'b0;
            bus.out_frm_err <= 1'b0;
            bus.out_valid   <= 1'b0;
            overrun         <= 1'b0;
            err_count       <= '0;
        end else begin
            // Handshake runs every cycle; a commit below overrides it.
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!serial_in) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg[bit_cnt] <= serial_in;
                        bit_cnt            <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= serial_in;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Return to idle whatever the stop value; a low stop
                        // bit is not treated as the next start bit.
                        state <= ST_IDLE;
                        if (!bus.out_valid || bus.out_ready) begin
                            bus.out_data    <= shift_reg;
                            bus.out_par_err <= par_err;
                            bus.out_frm_err <= frm_err;
                            bus.out_valid   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        if ((par_err || frm_err) && (err_count != '1)) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: an even-parity and an odd-parity
// instance receive the same serial stream; a frame-level reference model
// predicts every output, which is compared on each falling clock edge.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_en;
    logic       serial_in;
    logic       overrun_e, overrun_o;
    logic [7:0] err_count_e, err_count_o;

    parity_frame_rx_if #(.DATA_W(8)) ifc_e ();
    parity_frame_rx_if #(.DATA_W(8)) ifc_o ();

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0), .ERRCNT_W(8)) dut_e (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .serial_in (serial_in),
        .bus       (ifc_e.master),
        .overrun   (overrun_e),
        .err_count (err_count_e)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1), .ERRCNT_W(8)) dut_o (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .serial_in (serial_in),
        .bus       (ifc_o.master),
        .overrun   (overrun_o),
        .err_count (err_count_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model, index 0 = even instance, 1 = odd instance.
    logic [7:0] m_data [2];
    logic       m_perr [2];
    logic       m_ferr [2];
    logic       m_valid[2];
    logic       m_over [2];
    int unsigned m_cnt [2];

    // Frame currently being sent (used at its stop strobe).
    logic [7:0] f_data;
    logic       f_par;
    logic       f_stop;

    logic rdy_base;
    logic rdy_rand;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = '0; m_perr[i] = 0; m_ferr[i] = 0;
            m_valid[i] = 0; m_over[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input logic commit, input logic rdy);
        int unsigned ones;
        logic perr;
        for (int i = 0; i < 2; i++) begin
            if (commit) begin
                ones = $countones(f_data) + int'(f_par);
                perr = (i == 0) ? (ones % 2 == 1) : (ones % 2 == 0);
                if (!m_valid[i] || rdy) begin
                    m_data[i] = f_data; m_perr[i] = perr;
                    m_ferr[i] = !f_stop; m_valid[i] = 1;
                end else begin
                    m_over[i] = 1;
                end
                if ((perr || !f_stop) && m_cnt[i] < 255) m_cnt[i]++;
            end else if (m_valid[i] && rdy) begin
                m_valid[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        check("e.data",  32'(ifc_e.out_data),    32'(m_data[0]));
        check("e.perr",  32'(ifc_e.out_par_err), 32'(m_perr[0]));
        check("e.ferr",  32'(ifc_e.out_frm_err), 32'(m_ferr[0]));
        check("e.valid", 32'(ifc_e.out_valid),   32'(m_valid[0]));
        check("e.over",  32'(overrun_e),         32'(m_over[0]));
        check("e.cnt",   32'(err_count_e),       m_cnt[0]);
        check("o.data",  32'(ifc_o.out_data),    32'(m_data[1]));
        check("o.perr",  32'(ifc_o.out_par_err), 32'(m_perr[1]));
        check("o.ferr",  32'(ifc_o.out_frm_err), 32'(m_ferr[1]));
        check("o.valid", 32'(ifc_o.out_valid),   32'(m_valid[1]));
        check("o.over",  32'(overrun_o),         32'(m_over[1]));
        check("o.cnt",   32'(err_count_o),       m_cnt[1]);
    endtask

    // One clock: drive at the falling edge, update model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input logic en, input logic sin, input logic commit, input logic rdy);
        bit_en          = en;
        serial_in       = sin;
        ifc_e.out_ready = rdy;
        ifc_o.out_ready = rdy;
        @(posedge clk);
        model_step(commit, rdy);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic pick_rdy();
        return rdy_rand ? logic'($urandom_range(1, 0)) : rdy_base;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int unsigned gmax, input logic rdy_stop);
        logic [10:0] bits;
        int unsigned g;
        f_data = d; f_par = par; f_stop = stp;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) cycle(1'b1, bits[i], 1'b1, rdy_rand ? pick_rdy() : rdy_stop);
            else         cycle(1'b1, bits[i], 1'b0, pick_rdy());
            g = $urandom_range(gmax, 0);
            for (int unsigned j = 0; j < g; j++)
                cycle(1'b0, logic'($urandom_range(1, 0)), 1'b0, pick_rdy());
        end
    endtask

    task automatic drain();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; bit_en = 0; serial_in = 1;
        ifc_e.out_ready = 0; ifc_o.out_ready = 0;
        rdy_base = 0; rdy_rand = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Good even frame; valid appears one cycle after the stop strobe.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        check("t1.data",  32'(ifc_e.out_data),    32'h A5);
        check("t1.valid", 32'(ifc_e.out_valid),   32'h1);
        check("t1.perr",  32'(ifc_e.out_par_err), 32'h0);
        drain();

        // Single one with parity 0: even instance errors, odd does not.
        send_frame(8'h01, 1'b0, 1'b1, 2, 1'b0);
        check("t2.perr_e", 32'(ifc_e.out_par_err), 32'h1);
        check("t2.cnt_e",  32'(err_count_e),       32'h1);
        check("t2.perr_o", 32'(ifc_o.out_par_err), 32'h0);
        drain();

        // Framing error, then a clean frame.
        send_frame(8'h3C, 1'b0, 1'b0, 2, 1'b0);
        check("t3.ferr", 32'(ifc_e.out_frm_err), 32'h1);
        check("t3.cnt",  32'(err_count_e),       32'h2);
        drain();
        send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b0);
        check("t3.next", 32'(ifc_e.out_data),    32'h5A);
        check("t3.nf",   32'(ifc_e.out_frm_err), 32'h0);
        drain();

        // Overrun: second frame dropped, third loaded via same-cycle accept.
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0);
        check("t4.held", 32'(ifc_e.out_data), 32'h11);
        check("t4.over", 32'(overrun_e),      32'h1);
        send_frame(8'h33, 1'b0, 1'b1, 1, 1'b1);
        check("t4.load",  32'(ifc_e.out_data),  32'h33);
        check("t4.valid", 32'(ifc_e.out_valid), 32'h1);

        // Reset after four data bits clears everything immediately.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, logic'($urandom_range(1, 0)), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("t5.valid", 32'(ifc_e.out_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b1, 1, 1'b0);
        check("t5.data", 32'(ifc_e.out_data), 32'hC3);
        drain();

        // Randomised frames with random acceptance and strobe gaps.
        rdy_rand = 1;
        for (int n = 0; n < 40; n++)
            send_frame(8'($urandom), logic'($urandom_range(1, 0)),
                       ($urandom_range(3, 0) != 0), 3, 1'b0);
        rdy_rand = 0; rdy_base = 1;
        drain();

        // Error counter saturation.
        for (int n = 0; n < 260; n++)
            send_frame(8'($urandom), logic'($urandom_range(1, 0)), 1'b0, 2, 1'b1);
        check("t6.sat_e", 32'(err_count_e), 32'hFF);
        check("t6.sat_o", 32'(err_count_o), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
